// File: rtl/vga_pll_ctrl.sv
// Reset/lock sequencer for the VGA pixel-clock PLL: pulses the PLL reset, qualifies lock, releases vga_rst.
// Optional macro VGA_PLL_CTRL_RELOCK_RESET_EN: loss of lock in RUN re-pulses the PLL reset.
module vga_pll_ctrl #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_FILTER_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       vga_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_FILTER_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_FILTER_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_FILTER,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             sync_meta;
    logic             locked_s;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    // Next-state, retry and shared-counter logic
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        cnt_nxt   = cnt;
        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock beats a coincident timeout
                if (locked_s) begin
                    state_nxt = S_FILTER;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_count == RETRY_LIMIT) begin
                        state_nxt = S_FAULT;
                    end else begin
                        state_nxt = S_RESET_PLL;
                        retry_nxt = retry_count + 4'd1;
                    end
                end
            end
            S_FILTER: begin
                if (!locked_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == FILTER_LAST) begin
                    state_nxt = S_RUN;
                    retry_nxt = 4'd0;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
`ifdef VGA_PLL_CTRL_RELOCK_RESET_EN
                    state_nxt = S_RESET_PLL;
                    retry_nxt = 4'd0;
`else
                    state_nxt = S_WAIT_LOCK;
`endif
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_RESET_PLL;
                retry_nxt = 4'd0;
            end
        endcase

        // Counter restarts on every state change and idles in RUN/FAULT
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if ((state != S_RUN) && (state != S_FAULT)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // State register and Moore outputs registered from the next state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_RESET_PLL;
            cnt         <= '0;
            retry_count <= 4'd0;
            pll_rst     <= 1'b1;
            vga_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            pll_rst     <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
            vga_rst     <= (state_nxt != S_RUN);
            ready       <= (state_nxt == S_RUN);
            fault       <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_vga_pll_ctrl.sv
// Scoreboard bench for vga_pll_ctrl: a timeline model predicts every cycle's outputs, a monitor compares.
module tb_vga_pll_ctrl;

    localparam int RST_N  = 4;
    localparam int FILT_N = 8;
    localparam int TO_N   = 32;
    localparam int MAXR   = 2;
`ifdef VGA_PLL_CTRL_RELOCK_RESET_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_FILT  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       vga_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    typedef struct {
        int         edge_idx;
        logic [7:0] outs;
    } exp_t;

    exp_t exp_q[$];
    bit   lock_hist[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_n   = 0;
    int   m_phase  = PH_RESET;
    int   m_entered = 0;
    int   m_retries = 0;
    int   m_last_rst = 0;
    bit   m_valid  = 1'b0;

    vga_pll_ctrl #(
        .RST_PULSE_CYCLES   (RST_N),
        .LOCK_FILTER_CYCLES (FILT_N),
        .LOCK_TIMEOUT_CYCLES(TO_N),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .vga_rst    (vga_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Timeline model: lock is seen two edges after it is sampled, phases last whole cycle counts
    task automatic model_edge(input bit r, input bit l);
        bit         lk;
        int         el;
        int         nxt;
        exp_t       e;
        lock_hist.push_back(l);
        if (r) begin
            m_phase = PH_RESET; m_entered = edge_n; m_retries = 0;
            m_last_rst = edge_n; m_valid = 1'b1;
        end else if (m_valid) begin
            lk  = (edge_n - 2 > m_last_rst) ? lock_hist[edge_n - 2] : 1'b0;
            el  = edge_n - m_entered;
            nxt = m_phase;
            case (m_phase)
                PH_RESET: if (el == RST_N) nxt = PH_WAIT;
                PH_WAIT: begin
                    if (lk) nxt = PH_FILT;
                    else if (el == TO_N) begin
                        if (m_retries == MAXR) nxt = PH_FAULT;
                        else begin m_retries++; nxt = PH_RESET; end
                    end
                end
                PH_FILT: begin
                    if (!lk) nxt = PH_WAIT;
                    else if (el == FILT_N) begin nxt = PH_RUN; m_retries = 0; end
                end
                PH_RUN: if (!lk) nxt = RELOCK ? PH_RESET : PH_WAIT;
                default: nxt = m_phase;
            endcase
            if (nxt != m_phase) begin m_phase = nxt; m_entered = edge_n; end
        end
        if (m_valid) begin
            e.edge_idx = edge_n;
            e.outs = {(m_phase == PH_RESET) || (m_phase == PH_FAULT), m_phase != PH_RUN,
                      m_phase == PH_RUN, m_phase == PH_FAULT, 4'(m_retries)};
            exp_q.push_back(e);
        end
        edge_n++;
    endtask

    task automatic step(input bit r, input bit l);
        rst = r;
        pll_locked = l;
        @(posedge refclk);
        model_edge(r, l);
        #1;
    endtask

    task automatic run(input int n, input bit r, input bit l);
        for (int i = 0; i < n; i++) step(r, l);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // Monitor: every cycle the DUT presents a full output vector
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pll_rst, vga_rst, ready, fault, retry_count};
                n_checks++;
                if (act === e.outs) n_pass++;
                else $display("FAIL outputs@edge%0d: got prst/vrst/rdy/flt/retry=%b, want %b",
                              e.edge_idx, act, e.outs);
            end
        end
    end

    initial begin
        int c;
        int pulses;
        int lo;
        bit lv;
        rst = 1'b1;
        pll_locked = 1'b0;

        // Clean start
        run(3, 1'b1, 1'b0);
        check("reset_ready", int'(ready), 0);
        check("reset_retry", int'(retry_count), 0);
        pulses = int'(pll_rst);
        for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0); pulses += int'(pll_rst); end
        check("startup_pll_rst_cycles", pulses, RST_N);
        step(1'b0, 1'b1);
        c = 0;
        while (!ready && c < 40) begin step(1'b0, 1'b1); c++; end
        check("lock_to_ready", c, 2 + FILT_N);
        check("run_vga_rst", int'(vga_rst), 0);
        run(5, 1'b0, 1'b1);

        // Loss of lock in RUN, then relock
        step(1'b0, 1'b0);
        c = 0;
        while (ready && c < 10) begin step(1'b0, 1'b0); c++; end
        check("loss_to_not_ready", c, 2);
        pulses = int'(pll_rst);
        for (int i = 0; i < 8; i++) begin step(1'b0, 1'b0); pulses += int'(pll_rst); end
        check("relock_pll_rst_cycles", pulses, RELOCK ? RST_N : 0);
        step(1'b0, 1'b1);
        c = 0;
        while (!ready && c < 40) begin step(1'b0, 1'b1); c++; end
        check("relock_to_ready", c, 2 + FILT_N);

        // Glitchy lock aborts the filter
        run(2, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0);
        run(5, 1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        c = 0; pulses = 0;
        while (!ready && c < 40) begin step(1'b0, 1'b1); c++; pulses += int'(pll_rst); end
        check("glitch_final_rise_to_ready", c, 2 + FILT_N);
        check("glitch_no_pll_rst", pulses, 0);

        // Timeout, retries and fault
        run(2, 1'b1, 1'b0);
        pulses = int'(pll_rst);
        for (int i = 0; i < 130; i++) begin
            step(1'b0, 1'b0);
            if (!fault) pulses += int'(pll_rst);
        end
        check("fault_pll_rst_cycles", pulses, 3 * RST_N);
        check("fault_flag", int'(fault), 1);
        check("fault_retry", int'(retry_count), MAXR);
        run(20, 1'b0, 1'b1);
        check("fault_held", int'(fault), 1);

        // Reset on filter cycle 5
        run(2, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        run(6, 1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("midfilt_rst_pll_rst", int'(pll_rst), 1);
        check("midfilt_rst_vga_rst", int'(vga_rst), 1);
        check("midfilt_rst_retry", int'(retry_count), 0);
        run(20, 1'b0, 1'b1);
        check("midfilt_restart_ready", int'(ready), 1);

        // Lock around the last timeout cycle; offset 33 lands exactly on it
        for (int off = 31; off <= 36; off++) begin
            run(2, 1'b1, 1'b0);
            run(off, 1'b0, 1'b0);
            run(2, 1'b0, 1'b1);
            step(1'b0, 1'b1);
            if (off == 33) begin
                check("tie_retry_unchanged", int'(retry_count), 0);
                check("tie_no_pll_rst", int'(pll_rst), 0);
            end
            run(20, 1'b0, 1'b1);
        end

        // Randomized lock waveform with occasional resets
        lv = 1'b0;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                run(int'($urandom_range(1, 2)), 1'b1, lv);
            end else begin
                lv = ~lv;
                lo = lv ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 90));
                run(lo, 1'b0, lv);
            end
        end

        // Drain the scoreboard with a bounded wait
        c = 0;
        while (exp_q.size() > 0 && c < 5) begin @(posedge refclk); c++; end
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
